// File: rtl/irq_agg_pkg.sv
// Shared constants for the interrupt aggregator.
//   - register word addresses (ADDR_PENDING .. ADDR_ACK)
//   - ID_W / N_SRC_MAX: source ID width and maximum source count
//   - DATA_W: Avalon-MM data width
//   - VEC_VALID_BIT: position of the valid flag in the VECTOR register
package irq_agg_pkg;
  localparam int ID_W          = 4;
  localparam int N_SRC_MAX     = 16;
  localparam int DATA_W        = 16;
  localparam int VEC_VALID_BIT = 15;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_ACK     = 3'd5;
endpackage

// File: rtl/irq_agg_if.sv
// Avalon-MM slave bus used by the CPU to configure the aggregator.
//   master: address, chipselect, write_n, writedata out; readdata in
//   slave : the mirror image
interface irq_agg_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/irq_agg_input_stage.sv
// Per-source input conditioning: optional 2-flop synchronizer, one-cycle
// delayed copy (s_prev) and rising-edge detect.
//   clk, reset : clock, synchronous active-high reset
//   irq_in     : raw request line
//   s          : conditioned request
//   rise       : s & ~s_prev
// Build option: define IRQ_AGG_SYNC_EN to insert the synchronizer
// (adds 2 cycles of input latency).
module irq_agg_input_stage (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic s,
  output logic rise
);
`ifdef IRQ_AGG_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], irq_in};
  end
  assign s = sync[1];
`else
  assign s = irq_in;
`endif

  // s_prev resets low, so a source already high out of reset reads as a rise.
  logic s_prev;
  always_ff @(posedge clk) begin
    if (reset) s_prev <= 1'b0;
    else       s_prev <= s;
  end

  assign rise = s & ~s_prev;
endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: latches/tracks up to 16 request lines, masks them,
// picks the lowest-numbered active source and drives a registered irq/id.
//   clk, reset : clock, synchronous active-high reset
//   irq_in     : N_SRC request lines, bit i = source i
//   bus        : Avalon-MM slave (6 registers, 1-cycle registered reads)
//   irq_out    : registered interrupt to the CPU
//   irq_id     : registered winning source index
// Build option: IRQ_AGG_SYNC_EN (see irq_agg_input_stage).
module irq_aggregator
  import irq_agg_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_in,
  irq_agg_if.slave          bus,
  output logic              irq_out,
  output logic [ID_W-1:0]   irq_id
);
  logic [N_SRC-1:0] s, rise;
  logic [N_SRC-1:0] pending, mask, edge_en;
  logic [N_SRC-1:0] active, clr, pending_nx;
  logic [N_SRC-1:0] wr_data;
  logic [ID_W-1:0]  win;
  logic [DATA_W-1:0] rd_mux;
  logic             wr;

  irq_agg_input_stage u_in [N_SRC-1:0] (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .s      (s),
    .rise   (rise)
  );

  assign wr      = bus.chipselect & ~bus.write_n;
  assign wr_data = bus.writedata[N_SRC-1:0];
  assign active  = pending & mask;

  // Clear sources: W1C on PENDING, or ACK of a single in-range ID.
  always_comb begin
    clr = '0;
    if (wr && bus.address == ADDR_PENDING) clr = wr_data;
    if (wr && bus.address == ADDR_ACK) begin
      for (int i = 0; i < N_SRC; i++)
        if (bus.writedata[ID_W-1:0] == ID_W'(i)) clr[i] = 1'b1;
    end
  end

  // Edge bits use the current EDGE value; a mode write takes effect next cycle.
  // In edge mode a rise beats a same-cycle clear.
  always_comb begin
    pending_nx = '0;
    for (int i = 0; i < N_SRC; i++)
      pending_nx[i] = edge_en[i] ? (rise[i] | (pending[i] & ~clr[i])) : s[i];
  end

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (active[i]) win = ID_W'(i);
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_PENDING: rd_mux = DATA_W'(pending);
      ADDR_MASK:    rd_mux = DATA_W'(mask);
      ADDR_EDGE:    rd_mux = DATA_W'(edge_en);
      ADDR_ACTIVE:  rd_mux = DATA_W'(active);
      ADDR_VECTOR: begin
        rd_mux[VEC_VALID_BIT] = irq_out;
        rd_mux[ID_W-1:0]      = irq_id;
      end
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      mask         <= '0;
      edge_en      <= '0;
      irq_out      <= 1'b0;
      irq_id       <= '0;
      bus.readdata <= '0;
    end else begin
      pending <= pending_nx;
      if (wr && bus.address == ADDR_MASK) mask    <= wr_data;
      if (wr && bus.address == ADDR_EDGE) edge_en <= wr_data;
      irq_out      <= |active;
      irq_id       <= win;
      bus.readdata <= rd_mux;
    end
  end
endmodule
